alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have these parameters: PROG_DEPTH, 16, program memory entries; PC_W, 4, program counter width.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin program run at address 0; sampled in IDLE only.
- prog_we  in  1  program memory write strobe; honoured in IDLE only.
- prog_addr  in  PC_W  program write address.
- prog_data  in  20  instruction word {op[19:16], imm[15:0]}.
- alu_inst  out  4  opcode to the combinational ALU.
- alu_a  out  16  ALU operand a (accumulator).
- alu_b  out  16  ALU operand b (instruction immediate).
- alu_ans  in  17  ALU result; bit 16 is carry/borrow.
- acc  out  16  accumulator register.
- carry  out  1  carry flag register.
- busy  out  1  high in FETCH and EXEC.
- done  out  1  one-cycle pulse on program completion.

Function
REQ-003 The block SHALL have these opcodes: 0 movb, 1 movab, 2 add, 3 sub, 4 and, 5 incb, 6 decb, 7 xor, 8 nop, 9 clear, 10 or, 11-14 reserved, 15 halt.
REQ-004 The FSM SHALL have states IDLE, FETCH, EXEC, DONE, with transitions:
- IDLE->FETCH on start.
- FETCH->EXEC always.
- EXEC->FETCH if op!=15 and pc!=PROG_DEPTH-1.
- EXEC->DONE otherwise.
- DONE->IDLE always.
REQ-005 On the IDLE->FETCH transition, pc SHALL be loaded with 0.
REQ-006 In FETCH, ir SHALL register mem[pc] at the clock edge that ends FETCH.
REQ-007 In EXEC, alu_inst, alu_a, alu_b SHALL be: ir.op, acc, ir.imm respectively.
- Exception: for op 15 and ops 11-14, alu_inst SHALL be 8.
REQ-008 In every state other than EXEC, alu_inst SHALL be 8, alu_a SHALL be acc and alu_b SHALL be 0.
REQ-009 At the edge ending EXEC, for ops 0-7, 9 and 10, acc SHALL be set to alu_ans[15:0] and carry to alu_ans[16].
REQ-010 At the edge ending EXEC, for op 8, ops 11-14 and op 15, acc and carry SHALL hold.
REQ-011 At the edge ending EXEC, pc SHALL increment by 1 when the next state is FETCH; otherwise pc SHALL hold.
REQ-012 pc SHALL never wrap.
- Executing address PROG_DEPTH-1 SHALL end the run exactly as halt does.
REQ-013 Each executed instruction SHALL take 2 cycles.
- A program of N instructions ending in halt SHALL assert done 2N+1 cycles after the cycle in which start is sampled high.
REQ-014 done SHALL be high exactly in the DONE state, for one cycle.
REQ-015 busy SHALL be high in FETCH and EXEC only.
REQ-016 start SHALL be ignored in FETCH, EXEC and DONE.
REQ-017 prog_we SHALL be ignored in FETCH, EXEC and DONE.
REQ-018 A prog_we write SHALL take effect at the clock edge.
- A start in the same IDLE cycle SHALL see the written word if it targets address 0.
REQ-019 acc and carry SHALL persist across runs.
- Only reset, clear (op 9) or a writing op SHALL change them.
REQ-020 Program memory contents SHALL NOT be cleared by reset.

Reset
REQ-021 Assertion of reset SHALL, asynchronously and in any state, force:
- state IDLE; pc 0; ir 0; acc 0; carry 0.
- busy 0; done 0; alu_inst 8.
REQ-022 A run interrupted by reset SHALL NOT resume.
- A fresh start SHALL be required after reset is released.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load [0]={0,0x0005}, [1]={2,0x0003}, [2]={15,x}; pulse start -> done at cycle 7 after start, acc=0x0008, carry=0.
- acc=0x0000; program {3,0x0001},{15,x} -> acc=0xFFFF, carry=1.
- acc=0xFFFF; program {5,0xFFFF},{15,x} -> acc=0x0000, carry=1; then {8,x},{15,x} -> acc and carry unchanged, alu_inst=8 in every cycle.
- All 16 entries op 8 (no halt) -> run ends after address 15, done 33 cycles after start, pc=15, no wrap to 0.
- Assert reset during EXEC of instruction 2 -> same cycle: busy=0, acc=0, carry=0; program memory intact; a re-run gives the full-program result.
- prog_we and start asserted while busy -> memory unchanged and no restart; the original run completes with the expected acc.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute sequencer that runs a small program through an external combinational ALU,
// two cycles per instruction, ending on halt or on the last program address.
module alu_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [19:0]     prog_data,
  output logic [3:0]      alu_inst,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  input  logic [16:0]     alu_ans,
  output logic [15:0]     acc,
  output logic            carry,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic [19:0] ir;
  logic [19:0] mem [PROG_DEPTH];
  logic [3:0] op;
  logic writes, last;
  assign op = ir[19:16];
  always_comb begin
    writes = (op <= 4'd7) || (op == 4'd9) || (op == 4'd10);
    last = (op == 4'd15) || (pc == PC_W'(PROG_DEPTH - 1));
    state_nx = state == IDLE  ? (start ? FETCH : IDLE) :
               state == FETCH ? EXEC :
               state == EXEC  ? (last ? DONE : FETCH) : IDLE;
    busy = (state == FETCH) || (state == EXEC);
    done = state == DONE;
    alu_inst = (state == EXEC && op <= 4'd10) ? op : 4'd8;
    alu_a = acc;
    alu_b = state == EXEC ? ir[15:0] : '0;
  end
  // program memory is deliberately outside the reset domain so it survives reset
  always_ff @(posedge clk)
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      acc <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) pc <= '0;
      if (state == FETCH) ir <= mem[pc];
      if (state == EXEC && writes) begin
        acc <= alu_ans[15:0];
        carry <= alu_ans[16];
      end
      if (state == EXEC && state_nx == FETCH) pc <= pc + 1'b1;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs against a bench-side ALU; a scoreboard checks acc, carry and
// start-to-done latency on every done pulse.
module tb_alu_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic [3:0] alu_inst;
  logic [15:0] alu_a, alu_b, acc;
  logic [16:0] alu_ans;
  logic carry, busy, done;
  int tests = 0, fails = 0, cyc = 0, st_cyc = 0, dones = 0;
  bit nop_watch = 0;
  typedef struct {logic [15:0] acc; logic c; int lat;} exp_t;
  exp_t q[$];

  alu_sequencer #(.PROG_DEPTH(16), .PC_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ans(alu_ans), .acc(acc), .carry(carry), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // reference ALU; unused opcodes return a distinctive value so a wrongful write is visible
  always_comb
    case (alu_inst)
      4'd0: alu_ans = {1'b0, alu_b};
      4'd1: alu_ans = {1'b0, alu_a};
      4'd2: alu_ans = {1'b0, alu_a} + {1'b0, alu_b};
      4'd3: alu_ans = {1'b0, alu_a} - {1'b0, alu_b};
      4'd4: alu_ans = {1'b0, alu_a & alu_b};
      4'd5: alu_ans = {1'b0, alu_b} + 17'd1;
      4'd6: alu_ans = {1'b0, alu_b} - 17'd1;
      4'd7: alu_ans = {1'b0, alu_a ^ alu_b};
      4'd9: alu_ans = '0;
      4'd10: alu_ans = {1'b0, alu_a | alu_b};
      default: alu_ans = 17'h1_2345;
    endcase

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset && start && !busy && !done) st_cyc = cyc;
    if (nop_watch) chk("alu_inst_nop", 32'(alu_inst), 32'd8);
    if (done) begin
      dones++;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("acc", 32'(acc), 32'(e.acc));
        chk("carry", 32'(carry), 32'(e.c));
        chk("latency", 32'(cyc - st_cyc), 32'(e.lat));
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [3:0] op, input logic [15:0] imm);
    prog_we = 1'b1; prog_addr = a; prog_data = {op, imm};
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic run(input logic [15:0] ea, input logic ec, input int lat, input bit meddle);
    int d0;
    exp_t e;
    bit got = 0;
    e.acc = ea; e.c = ec; e.lat = lat;
    q.push_back(e);
    d0 = dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (meddle) begin
      @(posedge clk); #1;
      start = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = {4'd9, 16'h0000};
      @(posedge clk); #1;
      start = 1'b0; prog_we = 1'b0;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      got = dones != d0;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit hit = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_alu_inst", 32'(alu_inst), 32'd8);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    // 5 + 3 = 8
    wr(0, 0, 16'h0005); wr(1, 2, 16'h0003); wr(2, 15, 16'h0000);
    run(16'h0008, 1'b0, 7, 0);
    wr(0, 9, 16'h0000); wr(1, 15, 16'h0000);
    run(16'h0000, 1'b0, 5, 0);
    // 0 - 1 borrows
    wr(0, 3, 16'h0001);
    run(16'hFFFF, 1'b1, 5, 0);
    // 0xFFFF + 1 carries out
    wr(0, 5, 16'hFFFF);
    run(16'h0000, 1'b1, 5, 0);
    wr(0, 8, 16'h1234);
    nop_watch = 1;
    run(16'h0000, 1'b1, 5, 0);
    for (int i = 0; i < 16; i++) wr(4'(i), 8, 16'(i));
    run(16'h0000, 1'b1, 33, 0);
    nop_watch = 0;
    chk("pc_no_wrap", 32'(dut.pc), 32'd15);
    repeat (3) @(posedge clk); #1;
    chk("idle_after_last_addr", 32'(busy), 32'd0);
    // 5, 8, 0x18, 0x18^0xFF = 0xE7
    wr(0, 0, 16'h0005); wr(1, 2, 16'h0003); wr(2, 2, 16'h0010); wr(3, 7, 16'h00FF); wr(4, 15, 16'h0000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      hit = busy && alu_inst == 4'd2 && alu_b == 16'h0010;
    end
    if (!hit) chk("exec2_timeout", 32'd0, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_acc", 32'(acc), 32'd0);
    chk("async_carry", 32'(carry), 32'd0);
    chk("async_alu_inst", 32'(alu_inst), 32'd8);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("no_resume", 32'(busy), 32'd0);
    run(16'h00E7, 1'b0, 11, 0);
    run(16'h00E7, 1'b0, 11, 1);
    wr(0, 9, 16'h0000); wr(1, 15, 16'h0000);
    run(16'h0000, 1'b0, 5, 0);
    // a write honoured while busy would turn entry 3 into clear
    wr(0, 0, 16'h0005); wr(1, 2, 16'h0003);
    run(16'h00E7, 1'b0, 11, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
